// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, operator codes and parameter defaults
// for the calculator keypad sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FIRST     = 3'd1,
        S_WAIT_OPND = 3'd2,
        S_SECOND    = 3'd3,
        S_EXEC      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int MAX_DIGITS_DEF   = 8;
    localparam int EXEC_TIMEOUT_DEF = 15;

endpackage

// File: rtl/calc_edge_detect.sv
// calc_edge_detect: rising-edge detector for one keypad level.
// Ports: clk, reset_n (async, active-low), d (level in), rise (d=1 after a sample of 0).
// History resets to 1 so a level held high across reset release is not an event.
module calc_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic prev_q, prev_d;

    always_comb prev_d = d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= 1'b1;
        else          prev_q <= prev_d;
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven control FSM for a calculator datapath.
// Inputs : clk, reset_n (async, active-low), enter/number/total/clear keypad levels,
//          valid (qualifies enter/number), op_in (operator), alu_done/alu_err from the ALU.
// Outputs: one-cycle command pulses entry_shift, entry_clr, store, update, acc_clr, alu_start;
//          alu_op, show (1 = accumulator), err, state. All outputs are registered.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS   = MAX_DIGITS_DEF,
    parameter int EXEC_TIMEOUT = EXEC_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enter,
    input  logic       number,
    input  logic       total,
    input  logic       clear,
    input  logic       valid,
    input  logic [1:0] op_in,
    input  logic       alu_done,
    input  logic       alu_err,
    output logic       entry_shift,
    output logic       entry_clr,
    output logic       store,
    output logic       update,
    output logic       acc_clr,
    output logic       alu_start,
    output logic [1:0] alu_op,
    output logic       show,
    output logic       err,
    output logic [2:0] state
);

    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(EXEC_TIMEOUT + 1);

    logic enter_ev, number_ev, total_ev, clear_ev;

    calc_edge_detect u_ed_enter  (.clk(clk), .reset_n(reset_n), .d(enter),  .rise(enter_ev));
    calc_edge_detect u_ed_number (.clk(clk), .reset_n(reset_n), .d(number), .rise(number_ev));
    calc_edge_detect u_ed_total  (.clk(clk), .reset_n(reset_n), .d(total),  .rise(total_ev));
    calc_edge_detect u_ed_clear  (.clk(clk), .reset_n(reset_n), .d(clear),  .rise(clear_ev));

    state_t        state_q, state_d;
    logic          show_q, show_d, err_q, err_d;
    logic [1:0]    alu_op_q, alu_op_d, next_op_q, next_op_d;
    logic [DW-1:0] digits_q, digits_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          entry_shift_q, entry_shift_d, entry_clr_q, entry_clr_d;
    logic          store_q, store_d, update_q, update_d;
    logic          acc_clr_q, acc_clr_d, alu_start_q, alu_start_d;

    always_comb begin
        state_d       = state_q;
        show_d        = show_q;
        err_d         = err_q;
        alu_op_d      = alu_op_q;
        next_op_d     = next_op_q;
        digits_d      = digits_q;
        tmo_d         = tmo_q;
        entry_shift_d = 1'b0;
        entry_clr_d   = 1'b0;
        store_d       = 1'b0;
        update_d      = 1'b0;
        acc_clr_d     = 1'b0;
        alu_start_d   = 1'b0;
        if (clear_ev) begin
            acc_clr_d   = 1'b1;
            entry_clr_d = 1'b1;
            show_d      = 1'b0;
            err_d       = 1'b0;
            alu_op_d    = OP_ADD;
            next_op_d   = OP_ADD;
            digits_d    = '0;
            tmo_d       = '0;
            state_d     = S_IDLE;
        end else if (state_q == S_EXEC) begin
            // Only alu_done (or clear, above) can move EXEC; alu_op stays frozen here.
            if (alu_done && alu_err) begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end else if (alu_done) begin
                update_d    = 1'b1;
                entry_clr_d = 1'b1;
                show_d      = 1'b1;
                alu_op_d    = next_op_q;
                digits_d    = '0;
                state_d     = S_WAIT_OPND;
            end else if (tmo_q == TW'(EXEC_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else if (state_q != S_ERR) begin
            // A qualified event claims the cycle even when the current state ignores it.
            if (enter_ev && valid) begin
                if (state_q == S_FIRST) begin
                    store_d     = 1'b1;
                    entry_clr_d = 1'b1;
                    alu_op_d    = op_in;
                    digits_d    = '0;
                    state_d     = S_WAIT_OPND;
                end else if (state_q == S_WAIT_OPND) begin
                    alu_op_d = op_in;
                end else if (state_q == S_SECOND) begin
                    alu_start_d = 1'b1;
                    next_op_d   = op_in;
                    tmo_d       = '0;
                    state_d     = S_EXEC;
                end
            end else if (number_ev && valid) begin
                if (digits_q != DW'(MAX_DIGITS)) begin
                    entry_shift_d = 1'b1;
                    digits_d      = digits_q + 1'b1;
                    state_d       = (state_q == S_IDLE)      ? S_FIRST  :
                                    (state_q == S_WAIT_OPND) ? S_SECOND : state_q;
                end
            end else if (total_ev) begin
                show_d = ~show_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            show_q        <= 1'b0;
            err_q         <= 1'b0;
            alu_op_q      <= OP_ADD;
            next_op_q     <= OP_ADD;
            digits_q      <= '0;
            tmo_q         <= '0;
            entry_shift_q <= 1'b0;
            entry_clr_q   <= 1'b0;
            store_q       <= 1'b0;
            update_q      <= 1'b0;
            acc_clr_q     <= 1'b0;
            alu_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            show_q        <= show_d;
            err_q         <= err_d;
            alu_op_q      <= alu_op_d;
            next_op_q     <= next_op_d;
            digits_q      <= digits_d;
            tmo_q         <= tmo_d;
            entry_shift_q <= entry_shift_d;
            entry_clr_q   <= entry_clr_d;
            store_q       <= store_d;
            update_q      <= update_d;
            acc_clr_q     <= acc_clr_d;
            alu_start_q   <= alu_start_d;
        end
    end

    assign entry_shift = entry_shift_q;
    assign entry_clr   = entry_clr_q;
    assign store       = store_q;
    assign update      = update_q;
    assign acc_clr     = acc_clr_q;
    assign alu_start   = alu_start_q;
    assign alu_op      = alu_op_q;
    assign show        = show_q;
    assign err         = err_q;
    assign state       = state_q;

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter MAX_DIGITS, default 8: maximum digits accepted per operand.
REQ-002 Parameter EXEC_TIMEOUT, default 15: clk cycles allowed in EXEC before error.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enter, number, total, clear  input  1 each  keypad levels, synchronous to clk; events are rising edges.
REQ-006 valid  input  1  qualifies enter and number events.
REQ-007 op_in  input  2  operator code (00 ADD, 01 SUB, 10 MUL, 11 DIV), sampled on the enter event.
REQ-008 alu_done  input  1  one-cycle ALU completion strobe; alu_err  input  1  error flag, qualified by alu_done.
REQ-009 entry_shift, entry_clr, store, update, acc_clr, alu_start  output  1 each  one-cycle datapath command pulses.
REQ-010 alu_op  output  2  operator driven to the ALU.
REQ-011 show  output  1  display select (1 = accumulator, 0 = entry register); err  output  1  error indicator; state  output  3  current state.

Function
REQ-012 Each event input SHALL be edge-detected against its previous sample; an event is a sample of 1 following a sample of 0.
REQ-013 All outputs SHALL be registered; a command pulse SHALL be high for exactly one cycle, starting on the clk edge after the event is detected.
REQ-014 Same-cycle event priority SHALL be clear > enter > number > total; lower-priority events in that cycle SHALL be dropped.
REQ-015 States SHALL be IDLE, FIRST, WAIT_OPND, SECOND, EXEC and ERR.
REQ-016 clear in any state SHALL pulse acc_clr and entry_clr, set show=0, err=0, alu_op=00, digit count=0, and enter IDLE.
REQ-017 number with valid=1 in IDLE, FIRST, WAIT_OPND or SECOND SHALL pulse entry_shift and increment the digit count. IDLE goes to FIRST; WAIT_OPND goes to SECOND.
REQ-018 number with a digit count of MAX_DIGITS SHALL be ignored (no pulse, no state change).
REQ-019 enter with valid=1 in FIRST SHALL pulse store and entry_clr, latch op_in into alu_op, reset the digit count, and go to WAIT_OPND.
REQ-020 enter in WAIT_OPND SHALL only relatch op_in into alu_op.
REQ-021 enter in SECOND SHALL pulse alu_start with the current alu_op, latch op_in as the next operator, and go to EXEC.
REQ-022 enter in IDLE SHALL be ignored.
REQ-023 enter or number with valid=0 SHALL be ignored entirely.
REQ-024 alu_op SHALL hold stable from alu_start until EXEC exits.
REQ-025 In EXEC, alu_done with alu_err=0 SHALL pulse update and entry_clr, set show=1, load the next operator into alu_op, reset the digit count, and go to WAIT_OPND.
REQ-026 In EXEC, alu_done with alu_err=1 SHALL set err=1 and go to ERR.
REQ-027 A cycle counter SHALL run in EXEC; EXEC_TIMEOUT cycles without alu_done SHALL set err=1 and go to ERR.
REQ-028 In EXEC, all events except clear SHALL be ignored; alu_done outside EXEC SHALL be ignored.
REQ-029 total SHALL toggle show in IDLE, FIRST, WAIT_OPND and SECOND, and SHALL be ignored in EXEC and ERR.
REQ-030 ERR SHALL be left only by clear or reset.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, all pulses 0, show=0, err=0, alu_op=00, digit and timeout counters 0.
REQ-032 Edge-detect history registers SHALL reset to 1, so inputs held high across reset release generate no event.
REQ-033 Reset asserted mid-EXEC SHALL abandon the operation; a later alu_done SHALL be ignored.

Structure
REQ-034 Package calc_pkg SHALL hold the state encoding, operator codes, and the MAX_DIGITS and EXEC_TIMEOUT defaults.
REQ-035 Sub-module calc_edge_detect (one per event input, history reset value 1) SHALL perform the edge detection.

Verification
REQ-036 number x3, enter with op_in=00, number, enter with op_in=01, alu_done after 4 cycles -> entry_shift x4, store x1, alu_start with alu_op=00, then update with show=1, alu_op=01, state=WAIT_OPND.
REQ-037 number x9 from IDLE -> exactly 8 entry_shift pulses, state=FIRST.
REQ-038 alu_start with no alu_done for 15 cycles -> err=1, state=ERR; enter/number/total are then ignored; clear -> IDLE, err=0, acc_clr pulse.
REQ-039 clear and enter rising in the same cycle in SECOND -> acc_clr and entry_clr only, no alu_start, state=IDLE.
REQ-040 reset_n pulsed low while enter is held high, then released -> no store pulse and state=IDLE; reset during EXEC followed by alu_done -> no update pulse.
REQ-041 valid=0 with number and enter edges -> no pulses; total edge -> show toggles 0->1->0 on two events.
